// File: rtl/fft_peak_detect.sv
// Per-bin power (re^2 + im^2) of a streamed FFT frame in a 3-stage pipeline,
// forwarding a bin-tagged power stream and reporting the peak bin once per frame.
module fft_peak_detect #(
  parameter int N       = 16,
  parameter int LOG2N   = 4,
  parameter int DW      = 16,
  parameter int BIT_REV = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_push,
  input  logic [DW-1:0]      in_real,
  input  logic [DW-1:0]      in_imag,
  output logic               in_stall,
  output logic               out_push_F,
  output logic [LOG2N-1:0]   out_bin_F,
  output logic [2*DW:0]      out_power_F,
  output logic               out_last_F,
  input  logic               out_stall,
  output logic               peak_valid_F,
  output logic [LOG2N-1:0]   peak_bin_F,
  output logic [2*DW:0]      peak_power_F,
  output logic               err_F
);

  localparam int PW = 2*DW + 1;

  function automatic logic [2*DW-1:0] sq(input logic signed [DW-1:0] x);
    logic signed [2*DW-1:0] xe;
    xe = {{DW{x[DW-1]}}, x};
    return xe * xe;
  endfunction

  function automatic logic [PW-1:0] add_pwr(input logic [2*DW-1:0] a,
                                            input logic [2*DW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  logic             advance, accept;
  logic [LOG2N-1:0] cnt_q, cnt_d;

  logic [2*DW-1:0]  pre_p1_q, pre_p1_d, pim_p1_q, pim_p1_d;
  logic [LOG2N-1:0] bin_p1_q, bin_p1_d;
  logic             last_p1_q, last_p1_d, vld_p1_q, vld_p1_d;

  logic [PW-1:0]    pwr_p2_q, pwr_p2_d;
  logic [LOG2N-1:0] bin_p2_q, bin_p2_d;
  logic             last_p2_q, last_p2_d, vld_p2_q, vld_p2_d;

  logic             out_push_q, out_push_d, out_last_q, out_last_d;
  logic [LOG2N-1:0] out_bin_q, out_bin_d;
  logic [PW-1:0]    out_power_q, out_power_d;

  logic [PW-1:0]    max_q, max_d, cand_pwr, peak_power_q, peak_power_d;
  logic [LOG2N-1:0] max_bin_q, max_bin_d, cand_bin, peak_bin_q, peak_bin_d;
  logic             first_q, first_d, peak_valid_q, peak_valid_d, err_q, err_d;

  always_comb begin
    advance      = !out_stall;
    accept       = in_push & advance;
    cnt_d        = cnt_q;
    pre_p1_d     = pre_p1_q;
    pim_p1_d     = pim_p1_q;
    bin_p1_d     = bin_p1_q;
    last_p1_d    = last_p1_q;
    vld_p1_d     = vld_p1_q;
    pwr_p2_d     = pwr_p2_q;
    bin_p2_d     = bin_p2_q;
    last_p2_d    = last_p2_q;
    vld_p2_d     = vld_p2_q;
    out_push_d   = 1'b0;
    out_bin_d    = out_bin_q;
    out_power_d  = out_power_q;
    out_last_d   = out_last_q;
    max_d        = max_q;
    max_bin_d    = max_bin_q;
    first_d      = first_q;
    peak_valid_d = 1'b0;
    peak_bin_d   = peak_bin_q;
    peak_power_d = peak_power_q;
    err_d        = err_q | (in_push & out_stall);
    cand_pwr     = max_q;
    cand_bin     = max_bin_q;

    if (accept) cnt_d = cnt_q + LOG2N'(1);

    // Strict compare keeps the earlier arrival on ties; a frame's first sample always loads.
    if (first_q || (pwr_p2_q > max_q)) begin
      cand_pwr = pwr_p2_q;
      cand_bin = bin_p2_q;
    end

    if (advance) begin
      // Stage 1: squares of both components
      pre_p1_d  = sq(in_real);
      pim_p1_d  = sq(in_imag);
      bin_p1_d  = (BIT_REV != 0) ? bitrev(cnt_q) : cnt_q;
      last_p1_d = (cnt_q == LOG2N'(N-1));
      vld_p1_d  = accept;
      // Stage 2: power sum
      pwr_p2_d  = add_pwr(pre_p1_q, pim_p1_q);
      bin_p2_d  = bin_p1_q;
      last_p2_d = last_p1_q;
      vld_p2_d  = vld_p1_q;
      // Stage 3: output registers and peak tracking
      out_push_d  = vld_p2_q;
      out_bin_d   = bin_p2_q;
      out_power_d = pwr_p2_q;
      out_last_d  = last_p2_q;
      if (vld_p2_q) begin
        if (last_p2_q) begin
          peak_valid_d = 1'b1;
          peak_bin_d   = cand_bin;
          peak_power_d = cand_pwr;
          max_d        = '0;
          max_bin_d    = '0;
          first_d      = 1'b1;
        end else begin
          max_d        = cand_pwr;
          max_bin_d    = cand_bin;
          first_d      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      out_push_q   <= 1'b0;
      out_bin_q    <= '0;
      out_power_q  <= '0;
      out_last_q   <= 1'b0;
      max_q        <= '0;
      max_bin_q    <= '0;
      first_q      <= 1'b1;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_power_q <= '0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      out_push_q   <= out_push_d;
      out_bin_q    <= out_bin_d;
      out_power_q  <= out_power_d;
      out_last_q   <= out_last_d;
      max_q        <= max_d;
      max_bin_q    <= max_bin_d;
      first_q      <= first_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_power_q <= peak_power_d;
      err_q        <= err_d;
    end
  end

  // Internal stage data is qualified by its valid, so it carries no reset.
  always_ff @(posedge clk) begin
    pre_p1_q  <= pre_p1_d;
    pim_p1_q  <= pim_p1_d;
    bin_p1_q  <= bin_p1_d;
    last_p1_q <= last_p1_d;
    pwr_p2_q  <= pwr_p2_d;
    bin_p2_q  <= bin_p2_d;
    last_p2_q <= last_p2_d;
  end

  assign in_stall     = out_stall;
  assign out_push_F   = out_push_q;
  assign out_bin_F    = out_bin_q;
  assign out_power_F  = out_power_q;
  assign out_last_F   = out_last_q;
  assign peak_valid_F = peak_valid_q;
  assign peak_bin_F   = peak_bin_q;
  assign peak_power_F = peak_power_q;
  assign err_F        = err_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: latency, extremes, frame peak (both bin
// orderings), mid-frame stall, protocol violation and asynchronous reset.
module tb_fft_peak_detect;

  logic        clk, reset, in_push, out_stall;
  logic [15:0] in_real, in_imag;
  logic        in_stall, out_push_F, out_last_F, peak_valid_F, err_F;
  logic [3:0]  out_bin_F, peak_bin_F;
  logic [32:0] out_power_F, peak_power_F;
  logic        br_in_stall, br_out_push, br_out_last, br_peak_valid, br_err;
  logic [3:0]  br_out_bin, br_peak_bin;
  logic [32:0] br_out_power, br_peak_power;

  fft_peak_detect #(.N(16), .LOG2N(4), .DW(16), .BIT_REV(0)) u_dut (
    .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
    .in_stall(in_stall), .out_push_F(out_push_F), .out_bin_F(out_bin_F),
    .out_power_F(out_power_F), .out_last_F(out_last_F), .out_stall(out_stall),
    .peak_valid_F(peak_valid_F), .peak_bin_F(peak_bin_F), .peak_power_F(peak_power_F),
    .err_F(err_F));

  fft_peak_detect #(.N(16), .LOG2N(4), .DW(16), .BIT_REV(1)) u_dut_br (
    .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
    .in_stall(br_in_stall), .out_push_F(br_out_push), .out_bin_F(br_out_bin),
    .out_power_F(br_out_power), .out_last_F(br_out_last), .out_stall(out_stall),
    .peak_valid_F(br_peak_valid), .peak_bin_F(br_peak_bin), .peak_power_F(br_peak_power),
    .err_F(br_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  bin;
    logic [32:0] pwr;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] arr;
  int n_cmp = 0;
  int n_err = 0;
  int pk_cnt = 0;

  // Frame vectors: max power 10000 at arrival 5, tied at arrival 9.
  int          tre[16] = '{1, 2, 0, -3, 4, 60, 6, 0, -8, -100, 9, 6, 11, -12, 0, 14};
  int          tim[16] = '{0, 0, -3, 4, 0, -80, 0, 7, 0, 0, 0, 8, 0, 0, 13, 0};
  logic [32:0] tpw[16] = '{33'd1, 33'd4, 33'd9, 33'd25, 33'd16, 33'd10000, 33'd36, 33'd49,
                           33'd64, 33'd10000, 33'd81, 33'd100, 33'd121, 33'd144, 33'd169, 33'd196};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic drv(input logic p, input int re, input int im, input logic [32:0] pw,
                     input logic st);
    exp_t e;
    @(negedge clk);
    in_push   = p;
    in_real   = 16'(re);
    in_imag   = 16'(im);
    out_stall = st;
    if (p && !st) begin
      e.bin  = arr;
      e.pwr  = pw;
      e.last = (arr == 4'd15);
      exp_q.push_back(e);
      arr = arr + 4'd1;
    end
  endtask

  task automatic idle();
    drv(1'b0, 0, 0, 33'd0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_push"},   64'(out_push_F),   64'(0));
    chk({tag, "_bin"},    64'(out_bin_F),    64'(0));
    chk({tag, "_pwr"},    64'(out_power_F),  64'(0));
    chk({tag, "_last"},   64'(out_last_F),   64'(0));
    chk({tag, "_pkv"},    64'(peak_valid_F), 64'(0));
    chk({tag, "_pkbin"},  64'(peak_bin_F),   64'(0));
    chk({tag, "_pkpwr"},  64'(peak_power_F), 64'(0));
    chk({tag, "_err"},    64'(err_F),        64'(0));
  endtask

  // Output stream scoreboard: every result in order, peak pulse only with the last bin.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_push_F) begin
        chk("q_avail", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("out_bin",  64'(out_bin_F),    64'(mon_e.bin));
          chk("out_pwr",  64'(out_power_F),  64'(mon_e.pwr));
          chk("out_last", 64'(out_last_F),   64'(mon_e.last));
          chk("pk_vld",   64'(peak_valid_F), 64'(mon_e.last));
          if (mon_e.last) begin
            chk("pk_bin",     64'(peak_bin_F),    64'(5));
            chk("pk_pwr",     64'(peak_power_F),  64'(10000));
            chk("br_pk_vld",  64'(br_peak_valid), 64'(1));
            chk("br_pk_bin",  64'(br_peak_bin),   64'(10));
            chk("br_pk_pwr",  64'(br_peak_power), 64'(10000));
          end
        end
      end else if (peak_valid_F) begin
        chk("pk_orphan", 64'(peak_valid_F), 64'(out_push_F));
      end
      if (peak_valid_F) pk_cnt++;
    end
  end

  initial begin
    reset = 1'b1; in_push = 1'b0; out_stall = 1'b0;
    in_real = '0; in_imag = '0; arr = 4'd0;
    repeat (2) @(negedge clk);
    check_reset_state("rst0");
    chk("rst0_install", 64'(in_stall), 64'(0));
    reset = 1'b0;

    // Latency: push at edge k shows after edge k+2
    drv(1'b1, 3, 4, 33'd25, 1'b0);
    idle(); chk("lat_e0", 64'(out_push_F), 64'(0));
    idle(); chk("lat_e1", 64'(out_push_F), 64'(0));
    idle(); chk("lat_e2", 64'(out_push_F), 64'(1));
    chk("lat_pwr", 64'(out_power_F), 64'(25));
    chk("lat_bin", 64'(out_bin_F), 64'(0));

    // Extremes
    drv(1'b1, -32768, -32768, 33'h0_8000_0000, 1'b0);
    drv(1'b1, 32767, -32768, 33'h0_7FFF_0001, 1'b0);
    idle(); idle();
    chk("ext_a", 64'(out_power_F), 64'h0_8000_0000);
    idle();
    chk("ext_b", 64'(out_power_F), 64'h0_7FFF_0001);

    // Asynchronous reset mid-frame, outputs clear without a clock edge
    #2 reset = 1'b1;
    #1 check_reset_state("rst1");
    exp_q.delete();
    arr = 4'd0;
    @(negedge clk);
    reset = 1'b0;

    // Full frame; first result must be bin 0 after the reset
    for (int i = 0; i < 16; i++) drv(1'b1, tre[i], tim[i], tpw[i], 1'b0);
    repeat (4) idle();
    chk("f1_pkcnt", 64'(pk_cnt), 64'(1));
    chk("f1_drain", 64'(exp_q.size()), 64'(0));

    // Stall mid-frame with the pipeline full
    for (int i = 0; i < 8; i++) drv(1'b1, tre[i], tim[i], tpw[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 0, 0, 33'd0, 1'b1);
      chk("stl_install", 64'(in_stall), 64'(1));
      if (i > 0) begin
        chk("stl_push", 64'(out_push_F), 64'(0));
        chk("stl_hold", 64'(out_power_F), 64'(tpw[5]));
        chk("stl_hbin", 64'(out_bin_F), 64'(5));
      end
    end
    drv(1'b1, tre[8], tim[8], tpw[8], 1'b0);
    chk("stl_push3", 64'(out_push_F), 64'(0));
    chk("stl_hold3", 64'(out_power_F), 64'(tpw[5]));
    for (int i = 9; i < 16; i++) drv(1'b1, tre[i], tim[i], tpw[i], 1'b0);
    repeat (4) idle();
    chk("f2_pkcnt", 64'(pk_cnt), 64'(2));
    chk("f2_drain", 64'(exp_q.size()), 64'(0));
    chk("f2_err", 64'(err_F), 64'(0));

    // Protocol violation: push during stall is dropped
    for (int i = 0; i < 4; i++) drv(1'b1, tre[i], tim[i], tpw[i], 1'b0);
    drv(1'b1, 1000, 0, 33'd1000000, 1'b1);
    drv(1'b1, tre[4], tim[4], tpw[4], 1'b0);
    chk("vio_err", 64'(err_F), 64'(1));
    chk("vio_err_br", 64'(br_err), 64'(1));
    for (int i = 5; i < 16; i++) drv(1'b1, tre[i], tim[i], tpw[i], 1'b0);
    repeat (4) idle();
    chk("f3_pkcnt", 64'(pk_cnt), 64'(3));
    chk("f3_drain", 64'(exp_q.size()), 64'(0));
    chk("vio_sticky", 64'(err_F), 64'(1));

    // Reset clears sticky error and held peak
    #2 reset = 1'b1;
    #1 check_reset_state("rst2");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
